// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between N producers, the write-port arbiter and the fifo write side.
// The master side is the producers and fifo. The slave side is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N = 4,
    parameter int B = 8
);
    localparam int NW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*B-1:0] data;
    logic [N-1:0]   ack;
    logic           fifo_full;
    logic           fifo_wr;
    logic [B-1:0]   fifo_w_data;
    logic           busy;
    logic [NW-1:0]  owner;
    logic           timeout_evt;

    modport master (
        output req, last, data, fifo_full,
        input  ack, fifo_wr, fifo_w_data, busy, owner, timeout_evt
    );

    modport slave (
        input  req, last, data, fifo_full,
        output ack, fifo_wr, fifo_w_data, busy, owner, timeout_evt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one fifo write port among N producers.
// Define FIFO_ARB_STATS_EN to add per-requester word and forced-release counters.
module fifo_wr_arbiter #(
    parameter int N       = 4,
    parameter int B       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef FIFO_ARB_STATS_EN
    input  logic [$clog2(N)-1:0] stat_sel,
    output logic [15:0]          stat_words,
    output logic [7:0]           stat_timeouts,
`endif
    fifo_wr_arbiter_if.slave     bus
);
    localparam int NW = $clog2(N);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   owner_q, owner_d;
    logic [NW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;

    logic            grant_vld;
    logic [NW-1:0]   grant_idx;
    logic            own_req;
    logic            own_last;
    logic            xfer;
    logic            timeout_hit;

    // Search starts just after the last owner, so it becomes lowest priority.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_vld && bus.req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = NW'(idx);
            end
        end
    end

    assign own_req  = bus.req[owner_q];
    assign own_last = bus.last[owner_q];

    // Gated by reset so a word presented in the reset cycle never reaches the fifo.
    assign xfer = (state_q == LOCK) && own_req && !bus.fifo_full && !reset;

    assign timeout_hit = (TIMEOUT != 0) && (state_q == LOCK) && !own_req && !reset
                         && (idle_cnt_q == CW'(TIMEOUT - 1));

    // Data follows the registered owner even when no write happens.
    assign bus.fifo_w_data = bus.data[int'(owner_q) * B +: B];

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        idle_cnt_d      = idle_cnt_q;
        bus.ack         = '0;
        bus.fifo_wr     = 1'b0;
        bus.busy        = (state_q == LOCK);
        bus.owner       = owner_q;
        bus.timeout_evt = timeout_hit;

        if (xfer) begin
            bus.fifo_wr      = 1'b1;
            bus.ack[owner_q] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d    = LOCK;
                    owner_d    = grant_idx;
                    idle_cnt_d = '0;
                end
            end
            LOCK: begin
                if (own_req) begin
                    idle_cnt_d = '0;
                end else if (TIMEOUT != 0) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if ((xfer && own_last) || timeout_hit) begin
                    state_d    = IDLE;
                    rr_ptr_d   = owner_q;
                    idle_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= NW'(N - 1);
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] words_q [N];
    logic [7:0]  touts_q [N];

    // NOTE: the counter arrays are reset explicitly because software reads them as totals from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                words_q[i] <= '0;
                touts_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (xfer && owner_q == NW'(i) && words_q[i] != '1)
                    words_q[i] <= words_q[i] + 1'b1;
                if (timeout_hit && owner_q == NW'(i) && touts_q[i] != '1)
                    touts_q[i] <= touts_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_words    = '0;
        stat_timeouts = '0;
        if (int'(stat_sel) < N) begin
            stat_words    = words_q[stat_sel];
            stat_timeouts = touts_q[stat_sel];
        end
    end
`endif

    a_ack_onehot : assert property (@(posedge clk) $onehot0(bus.ack));
    a_wr_is_ack  : assert property (@(posedge clk) bus.fifo_wr == (|bus.ack));
    a_no_wr_full : assert property (@(posedge clk) !(bus.fifo_wr && bus.fifo_full));

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one fifo write port among N producers, e.g. several agents feeding one UART TX queue.
- Round-robin choice among requesters; the winner keeps the port until its packet ends, so packets never interleave.
- Words move only when fifo_full is low; each accepted word gets a one-cycle ack.
- A stalled owner is released after a programmable idle timeout.

Parameters:
- N, 4, number of requesters, legal range 2..8; NW = $clog2(N) is a localparam.
- B, 8, word width; must equal the fifo B.
- TIMEOUT, 16, consecutive cycles the owner may hold req low before forced release; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  N  per-requester word valid; bit i belongs to requester i
- last  in  N  marks the final word of a packet; sampled only with req
- data  in  N*B  requester i word on bits [i*B +: B]
- ack  out  N  one-hot pulse: word of requester i written this cycle
- fifo_full  in  1  from fifo.full
- fifo_wr  out  1  to fifo.wr
- fifo_w_data  out  B  to fifo.w_data
- busy  out  1  high in LOCK state
- owner  out  NW  index of the current owner; valid while busy
- timeout_evt  out  1  one-cycle pulse when a forced release happens

Behaviour:
- Reset values: state=IDLE, owner=0, rr_ptr=N-1, idle_cnt=0, ack=0, fifo_wr=0, busy=0, timeout_evt=0.
- IDLE state:
  - Search req starting at index rr_ptr+1 mod N, ascending with wrap.
  - The first set bit is registered as owner, and state goes to LOCK next cycle.
  - No word is transferred in the IDLE cycle, so arbitration latency is 1 cycle.
- LOCK state, datapath combinational from registered owner:
  - xfer = req[owner] & ~fifo_full.
  - fifo_wr = xfer; ack = xfer << owner; fifo_w_data = data[owner].
  - fifo_w_data is always driven from the owner slice, even when fifo_wr=0.
- End of packet: xfer & last[owner] sets state to IDLE and rr_ptr to owner, so that requester has lowest priority next round.
- Back-to-back packets: a packet's last word and the next grant are separated by exactly one IDLE cycle.
- Back-pressure: while fifo_full=1 there is no ack and no fifo_wr. The owner must hold req, last and data stable until ack.
- Timeout:
  - In LOCK, idle_cnt increments on each cycle with req[owner]=0, and clears on any cycle with req[owner]=1.
  - A cycle with fifo_full=1 and req[owner]=1 is not idle.
  - When idle_cnt reaches TIMEOUT (nonzero), the next state is IDLE, rr_ptr=owner, timeout_evt=1 for that cycle, and idle_cnt clears.
- Non-owner req is ignored in LOCK, and its ack stays 0.
- No requests in IDLE: the state holds and all outputs stay at reset values.
- last without req has no effect.
- Reset mid-packet returns to the reset values on the next edge; a word presented in the reset cycle is not written.
- Invariants: ack is never more than one-hot, and fifo_wr equals |ack. fifo_wr is never asserted while fifo_full=1, so the fifo's own full protection is never relied upon.

Optional Feature:
- FIFO_ARB_STATS_EN defined:
  - Adds input stat_sel (NW), output stat_words (16) and output stat_timeouts (8).
  - Per requester, a saturating counter of accepted words (16 bits) and of forced releases (8 bits).
  - The outputs show the counters of requester stat_sel, combinational.
  - Counters clear on reset and stick at all-ones.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- req=4'b0110, 3-word packets with last on word 3, fifo_full=0 -> owner 1 first (rr_ptr reset 3 searches from 0), acks on cycles 2,3,4; owner 2 granted cycle 6; fifo receives 6 words in order.
- Requester 0 and requester 3 always requesting 1-word packets -> grants alternate 0,3,0,3; each ack separated by one IDLE cycle.
- Owner mid-packet, fifo_full=1 for 5 cycles -> fifo_wr=0 and ack=0 for those 5 cycles; the held word is written on the first cycle full drops; no word is lost or duplicated.
- TIMEOUT=4, owner 2 drops req after word 1 -> timeout_evt pulses on the 4th idle cycle; pending requester 3 is granted next; requester 2 loses priority.
- Reset asserted in LOCK with req held -> next cycle busy=0, ack=0, fifo_wr=0; re-arbitration starts from requester 0.
- FIFO_ARB_STATS_EN defined, requester 1 sends 70000 words -> stat_sel=1 gives stat_words=16'hFFFF, stat_timeouts=0.
